// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU definitions used by the instruction fetch unit: state encoding,
// fault causes, bus size code and the default reset vector.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } fetchState_t;

  typedef enum logic {
    FAULT_MISALIGNED = 1'b0,
    FAULT_TIMEOUT    = 1'b1
  } faultCause_t;

  localparam logic [1:0]  BUS_SIZE_WORD        = 2'b10;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'he0000000;

  function automatic logic isWordAligned(input logic [31:0] address);
    return address[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_timeout_counter.sv
// Counts wait-state cycles of one bus transfer; expired fires in the wait
// cycle that makes the count reach TIMEOUT_CYCLES (never when that is 0).
module fetch_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic increment,
  output logic expired
);

  localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [COUNT_WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (increment) begin
      count <= count + COUNT_WIDTH'(1);
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : gNoTimeout
      assign expired = 1'b0;
    end else begin : gTimeout
      assign expired = increment && (count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/instruction_fetch_unit.sv
// Owns the program counter and performs one word read per fetch request,
// writing the instruction register in the cycle the bus delivers the word.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = DEFAULT_RESET_VECTOR,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetchStart,
  input  logic        pcLoadEnable,
  input  logic [31:0] pcLoadValue,
  input  logic        busWait,
  output logic        busEnable,
  output logic        busWrite,
  output logic [1:0]  busSize,
  output logic [31:0] busAddress,
  output logic        instructionRegisterWriteEnable,
  output logic [31:0] programCounter,
  output logic [31:0] fetchedPc,
  output logic        fetchDone,
  output logic        fetchFaultMisaligned,
  output logic        fetchFaultTimeout
);

  fetchState_t state, nextState;
  faultCause_t faultCause;
  logic        pendingValid;
  logic [31:0] pendingPc;
  logic [31:0] effectivePc;
  logic        startAligned;
  logic        timeoutExpired;

  // A redirect in the same cycle as a fetch request decides the fetch address.
  assign effectivePc  = pcLoadEnable ? pcLoadValue : programCounter;
  assign startAligned = (state == IDLE) && fetchStart && isWordAligned(effectivePc);

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) timeoutCounter (
    .clock    (clock),
    .reset    (reset),
    .clear    (startAligned),
    .increment((state == BUS) && busWait),
    .expired  (timeoutExpired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (fetchStart) nextState = isWordAligned(effectivePc) ? BUS : FAULT;
      BUS:     if (!busWait) nextState = DONE;
               else if (timeoutExpired) nextState = FAULT;
      DONE:    nextState = IDLE;
      FAULT:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busEnable                      = (state == BUS);
    instructionRegisterWriteEnable = (state == BUS) && !busWait;
    fetchDone                      = (state == DONE);
    fetchFaultMisaligned           = (state == FAULT) && (faultCause == FAULT_MISALIGNED);
    fetchFaultTimeout              = (state == FAULT) && (faultCause == FAULT_TIMEOUT);
  end

  assign busWrite   = 1'b0;
  assign busSize    = BUS_SIZE_WORD;
  assign busAddress = programCounter;

  // Redirects arriving mid-transfer are parked and applied when BUS is left.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      programCounter <= RESET_VECTOR;
      fetchedPc      <= RESET_VECTOR;
      pendingValid   <= 1'b0;
      pendingPc      <= '0;
      faultCause     <= FAULT_MISALIGNED;
    end else if (state == BUS) begin
      if (!busWait || timeoutExpired) begin
        if (pcLoadEnable) begin
          programCounter <= pcLoadValue;
        end else if (pendingValid) begin
          programCounter <= pendingPc;
        end else if (!busWait) begin
          programCounter <= programCounter + 32'd4;
        end
        if (!busWait) begin
          fetchedPc <= programCounter;
        end else begin
          faultCause <= FAULT_TIMEOUT;
        end
        pendingValid <= 1'b0;
      end else if (pcLoadEnable) begin
        pendingValid <= 1'b1;
        pendingPc    <= pcLoadValue;
      end
    end else begin
      pendingValid <= 1'b0;
      if (pcLoadEnable) begin
        programCounter <= pcLoadValue;
      end
      if ((state == IDLE) && fetchStart && !isWordAligned(effectivePc)) begin
        faultCause <= FAULT_MISALIGNED;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a transaction-level model plans
// each fetch's cycle-by-cycle outcome and one process compares every cycle.
module tb_instruction_fetch_unit;

  localparam int          TIMEOUT = 4;
  localparam logic [31:0] RV      = 32'he0000000;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetchStart;
  logic        pcLoadEnable;
  logic [31:0] pcLoadValue;
  logic        busWait;
  logic        busEnable;
  logic        busWrite;
  logic [1:0]  busSize;
  logic [31:0] busAddress;
  logic        instructionRegisterWriteEnable;
  logic [31:0] programCounter;
  logic [31:0] fetchedPc;
  logic        fetchDone;
  logic        fetchFaultMisaligned;
  logic        fetchFaultTimeout;

  logic [31:0] busReadData;
  logic [31:0] benchIr;

  int testsRun    = 0;
  int testsFailed = 0;

  bit          checkEnable = 1'b0;
  logic        expBusEnable, expIrWrite, expDone, expMisaligned, expTimeout;
  logic [31:0] modelPc, modelFetchedPc;

  instruction_fetch_unit #(
    .RESET_VECTOR  (RV),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock                         (clock),
    .reset                         (reset),
    .fetchStart                    (fetchStart),
    .pcLoadEnable                  (pcLoadEnable),
    .pcLoadValue                   (pcLoadValue),
    .busWait                       (busWait),
    .busEnable                     (busEnable),
    .busWrite                      (busWrite),
    .busSize                       (busSize),
    .busAddress                    (busAddress),
    .instructionRegisterWriteEnable(instructionRegisterWriteEnable),
    .programCounter                (programCounter),
    .fetchedPc                     (fetchedPc),
    .fetchDone                     (fetchDone),
    .fetchFaultMisaligned          (fetchFaultMisaligned),
    .fetchFaultTimeout             (fetchFaultTimeout)
  );

  always #5 clock = ~clock;

  // Stand-in for the downstream instruction register.
  always @(posedge clock) begin
    if (instructionRegisterWriteEnable) benchIr <= busReadData;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutputBit(input string name, input logic actual, input logic expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    if (checkEnable) begin
      checkOutputBit("busEnable", busEnable, expBusEnable);
      checkOutputBit("irWrite", instructionRegisterWriteEnable, expIrWrite);
      checkOutputBit("fetchDone", fetchDone, expDone);
      checkOutputBit("faultMisaligned", fetchFaultMisaligned, expMisaligned);
      checkOutputBit("faultTimeout", fetchFaultTimeout, expTimeout);
      checkOutputBit("busWrite", busWrite, 1'b0);
      checkOutput("busSize", {30'b0, busSize}, 32'h2);
      checkOutput("programCounter", programCounter, modelPc);
      checkOutput("busAddress", busAddress, modelPc);
      checkOutput("fetchedPc", fetchedPc, modelFetchedPc);
    end
  end

  // Drives one cycle's inputs and expected outputs, returning after the compare.
  task automatic applyStimulus(input logic fs, input logic ld, input logic [31:0] ldVal,
                               input logic wt, input logic eBus, input logic eWe,
                               input logic eDone, input logic eMis, input logic eTo);
    @(posedge clock);
    #1;
    fetchStart    = fs;
    pcLoadEnable  = ld;
    pcLoadValue   = ldVal;
    busWait       = wt;
    expBusEnable  = eBus;
    expIrWrite    = eWe;
    expDone       = eDone;
    expMisaligned = eMis;
    expTimeout    = eTo;
    @(negedge clock);
    #1;
  endtask

  task automatic redirectTo(input logic [31:0] target);
    applyStimulus(1'b0, 1'b1, target, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    modelPc = target;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One fetch: waits >= TIMEOUT means the bus never answers.
  task automatic runFetch(input int waits, input logic idleLoad, input logic [31:0] idleLoadVal,
                          input int loadBusCycle, input logic [31:0] loadVal,
                          input logic [31:0] data, input logic holdStart);
    logic [31:0] effPc;
    logic [31:0] pendPc;
    logic        pendValid;
    logic        wt;
    logic        timedOut;
    int          busCycles;
    busReadData = data;
    applyStimulus(1'b1, idleLoad, idleLoadVal, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    effPc   = idleLoad ? idleLoadVal : modelPc;
    modelPc = effPc;
    if (effPc[1:0] != 2'b00) begin
      applyStimulus(holdStart, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      return;
    end
    timedOut  = (waits >= TIMEOUT);
    busCycles = timedOut ? TIMEOUT : waits + 1;
    pendValid = 1'b0;
    pendPc    = 32'h0;
    for (int i = 0; i < busCycles; i++) begin
      wt = (i < waits);
      applyStimulus(holdStart, (i == loadBusCycle), loadVal, wt, 1'b1, !wt, 1'b0, 1'b0, 1'b0);
      if (i == loadBusCycle) begin
        pendValid = 1'b1;
        pendPc    = loadVal;
      end
    end
    if (timedOut) begin
      if (pendValid) modelPc = pendPc;
      applyStimulus(holdStart, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end else begin
      modelFetchedPc = modelPc;
      modelPc        = pendValid ? pendPc : modelPc + 32'd4;
      applyStimulus(holdStart, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("instrRegister", benchIr, data);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    fetchStart     = 1'b0;
    pcLoadEnable   = 1'b0;
    pcLoadValue    = 32'h0;
    busWait        = 1'b0;
    busReadData    = 32'h0;
    expBusEnable   = 1'b0;
    expIrWrite     = 1'b0;
    expDone        = 1'b0;
    expMisaligned  = 1'b0;
    expTimeout     = 1'b0;
    modelPc        = RV;
    modelFetchedPc = RV;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("resetPc", programCounter, 32'he0000000);
    checkOutput("resetFetchedPc", fetchedPc, 32'he0000000);
    checkOutputBit("resetBusEnable", busEnable, 1'b0);
    checkEnable = 1'b1;

    runFetch(0, 1'b0, 32'h0, -1, 32'h0, 32'h12345678, 1'b0);
    checkOutput("firstFetchPc", programCounter, 32'he0000004);
    checkOutput("firstFetchedPc", fetchedPc, 32'he0000000);

    runFetch(2, 1'b0, 32'h0, -1, 32'h0, 32'hcafef00d, 1'b1);
    checkOutput("waitedFetchPc", programCounter, 32'he0000008);

    runFetch(10, 1'b0, 32'h0, -1, 32'h0, 32'hdeadbeef, 1'b0);
    checkOutput("timeoutPcKept", programCounter, 32'he0000008);
    checkOutput("timeoutIrKept", benchIr, 32'hcafef00d);
    checkOutput("timeoutFetchedPcKept", fetchedPc, 32'he0000004);

    redirectTo(32'h00001002);
    runFetch(0, 1'b0, 32'h0, -1, 32'h0, 32'h55555555, 1'b0);
    checkOutput("misalignedPc", programCounter, 32'h00001002);

    runFetch(0, 1'b1, 32'hfffffffc, -1, 32'h0, 32'h0badc0de, 1'b0);
    checkOutput("wrapPc", programCounter, 32'h00000000);
    checkOutput("wrapFetchedPc", fetchedPc, 32'hfffffffc);

    runFetch(1, 1'b0, 32'h0, 0, 32'h00000100, 32'h11112222, 1'b0);
    checkOutput("redirectPc", programCounter, 32'h00000100);
    checkOutput("redirectFetchedPc", fetchedPc, 32'h00000000);

    runFetch(0, 1'b0, 32'h0, -1, 32'h0, 32'h33334444, 1'b0);
    checkOutput("afterRedirectFetchedPc", fetchedPc, 32'h00000100);
    checkOutput("afterRedirectPc", programCounter, 32'h00000104);

    runFetch(10, 1'b0, 32'h0, 1, 32'h00000200, 32'h66667777, 1'b0);
    checkOutput("timeoutRedirectPc", programCounter, 32'h00000200);

    // Reset arrives in the second wait cycle of a transfer.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    expBusEnable   = 1'b0;
    expIrWrite     = 1'b0;
    modelPc        = RV;
    modelFetchedPc = RV;
    reset          = 1'b1;
    #1;
    checkOutputBit("resetDropsBus", busEnable, 1'b0);
    checkOutput("resetMidBusPc", programCounter, 32'he0000000);
    @(negedge clock);
    #1;
    reset   = 1'b0;
    busWait = 1'b0;
    idleCycles(3);

    runFetch(0, 1'b0, 32'h0, -1, 32'h0, 32'h89abcdef, 1'b0);
    checkOutput("postResetPc", programCounter, 32'he0000004);

    checkEnable = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
